game_fsm: RTL and testbench

GAME_FSM -- requirements
Module: game_fsm

---
 rtl/enum_type.sv | 36 +++
 rtl/game_fsm.sv | 186 ++++++++++++++++++
 tb/tb_game_fsm.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/enum_type.sv
// rtl/enum_type.sv - shared state/command enum, piece-kind constant and score lookup
package enum_type;

    typedef enum logic [3:0] {
        NONE       = 4'd0,
        LEFT       = 4'd1,
        RIGHT      = 4'd2,
        DOWN       = 4'd3,
        DROP       = 4'd4,
        HOLD       = 4'd5,
        ROTATE     = 4'd6,
        ROTATE_REV = 4'd7,
        BAR        = 4'd8,
        WAIT       = 4'd9,
        INIT       = 4'd10,
        NEW        = 4'd11,
        CHECK      = 4'd12,
        LOCK       = 4'd13,
        CLEAR      = 4'd14,
        OVER       = 4'd15
    } state_type;

    localparam logic [2:0] BAR_KIND = 3'd0;

    // Points for 0..4 cleared lines; anything larger is not a legal count
    function automatic logic [15:0] clear_points(input logic [2:0] lines);
        case (lines)
            3'd1:    clear_points = 16'd100;
            3'd2:    clear_points = 16'd300;
            3'd3:    clear_points = 16'd500;
            3'd4:    clear_points = 16'd800;
            default: clear_points = 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/game_fsm.sv
// rtl/game_fsm.sv - falling-piece game controller: command decode, collision/lock/clear handshakes, score
module game_fsm
    import enum_type::*;
#(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int SPAWN_X = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  state_type         control,
    output state_type         state,
    input  logic [2:0]        next_kind,
    output logic              next_ack,
    output logic signed [4:0] cand_x,
    output logic signed [5:0] cand_y,
    output logic [1:0]        cand_rot,
    output logic [2:0]        cand_kind,
    output logic              chk_req,
    input  logic              chk_done,
    input  logic              chk_hit,
    output logic              lock_req,
    input  logic              lock_done,
    output logic              clr_req,
    input  logic              clr_done,
    input  logic [2:0]        clr_lines,
    output logic [15:0]       score
);

    localparam logic signed [4:0] SPAWN_COL = (SPAWN_X < BOARD_W) ? 5'(SPAWN_X) : 5'sd0;
    localparam logic signed [5:0] MAX_Y     = 6'(BOARD_H);

    logic signed [4:0] x;
    logic signed [5:0] y;
    logic [1:0]        rot;
    logic [2:0]        kind;
    logic [2:0]        hold_kind;
    logic              hold_valid;
    logic              hold_used;
    state_type         cmd;
    logic [16:0]       score_sum;

    assign score_sum = {1'b0, score} + {1'b0, clear_points(clr_lines)};

    function automatic logic signed [5:0] step_y(input logic signed [5:0] cur);
        step_y = (cur < MAX_Y) ? cur + 6'sd1 : cur;
    endfunction

    // Request pulses are set on the edge entering the state that owns them,
    // so they and the candidate are valid together for exactly that state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= INIT;
            cmd        <= NONE;
            x          <= '0;
            y          <= '0;
            rot        <= '0;
            kind       <= '0;
            hold_kind  <= '0;
            hold_valid <= 1'b0;
            hold_used  <= 1'b0;
            cand_x     <= '0;
            cand_y     <= '0;
            cand_rot   <= '0;
            cand_kind  <= '0;
            next_ack   <= 1'b0;
            chk_req    <= 1'b0;
            lock_req   <= 1'b0;
            clr_req    <= 1'b0;
            score      <= '0;
        end else begin
            next_ack <= 1'b0;
            chk_req  <= 1'b0;
            lock_req <= 1'b0;
            clr_req  <= 1'b0;
            case (state)
                INIT: begin
                    state     <= NEW;
                    next_ack  <= 1'b1;
                    chk_req   <= 1'b1;
                    cand_x    <= SPAWN_COL;
                    cand_y    <= '0;
                    cand_rot  <= '0;
                    cand_kind <= next_kind;
                end
                NEW: begin
                    x         <= cand_x;
                    y         <= cand_y;
                    rot       <= cand_rot;
                    kind      <= cand_kind;
                    hold_used <= 1'b0;
                    cmd       <= NEW;
                    state     <= CHECK;
                end
                WAIT: begin
                    if (control inside {LEFT, RIGHT, DOWN, DROP, HOLD, ROTATE, ROTATE_REV, BAR}) begin
                        state     <= control;
                        cmd       <= control;
                        chk_req   <= !(control == HOLD && hold_used);
                        cand_x    <= x;
                        cand_y    <= y;
                        cand_rot  <= rot;
                        cand_kind <= kind;
                        case (control)
                            LEFT:       cand_x    <= x - 5'sd1;
                            RIGHT:      cand_x    <= x + 5'sd1;
                            DOWN, DROP: cand_y    <= step_y(y);
                            ROTATE:     cand_rot  <= rot + 2'd1;
                            ROTATE_REV: cand_rot  <= rot - 2'd1;
                            BAR:        cand_kind <= BAR_KIND;
                            HOLD: begin
                                if (!hold_used) begin
                                    cand_x    <= SPAWN_COL;
                                    cand_y    <= '0;
                                    cand_rot  <= '0;
                                    cand_kind <= hold_valid ? hold_kind : next_kind;
                                    next_ack  <= !hold_valid;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                HOLD: begin
                    if (hold_used) begin
                        state <= WAIT;
                    end else begin
                        hold_kind  <= kind;
                        hold_valid <= 1'b1;
                        hold_used  <= 1'b1;
                        x          <= cand_x;
                        y          <= cand_y;
                        rot        <= cand_rot;
                        kind       <= cand_kind;
                        state      <= CHECK;
                    end
                end
                LEFT, RIGHT, DOWN, DROP, ROTATE, ROTATE_REV, BAR: state <= CHECK;
                CHECK: begin
                    if (chk_done) begin
                        if (!chk_hit) begin
                            x    <= cand_x;
                            y    <= cand_y;
                            rot  <= cand_rot;
                            kind <= cand_kind;
                            if (cmd == DROP) begin
                                state   <= DROP;
                                chk_req <= 1'b1;
                                cand_y  <= step_y(cand_y);
                            end else begin
                                state <= WAIT;
                            end
                        end else if (cmd == DOWN || cmd == DROP) begin
                            state    <= LOCK;
                            lock_req <= 1'b1;
                        end else if (cmd == NEW || cmd == HOLD) begin
                            state <= OVER;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                LOCK: begin
                    if (lock_done) begin
                        clr_req <= 1'b1;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (clr_done) begin
                        score     <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                        state     <= NEW;
                        next_ack  <= 1'b1;
                        chk_req   <= 1'b1;
                        cand_x    <= SPAWN_COL;
                        cand_y    <= '0;
                        cand_rot  <= '0;
                        cand_kind <= next_kind;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_fsm.sv
// tb/tb_game_fsm.sv - randomized scoreboard bench for game_fsm against a piece-level reference model
module tb_game_fsm;
    import enum_type::*;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    state_type         control = NONE;
    state_type         state;
    logic [2:0]        next_kind = 3'd0;
    logic              next_ack;
    logic signed [4:0] cand_x;
    logic signed [5:0] cand_y;
    logic [1:0]        cand_rot;
    logic [2:0]        cand_kind;
    logic              chk_req, lock_req, clr_req;
    logic              chk_done = 1'b0, chk_hit = 1'b0, lock_done = 1'b0, clr_done = 1'b0;
    logic [2:0]        clr_lines = 3'd0;
    logic [15:0]       score;

    always #5 clk = ~clk;

    game_fsm #(.BOARD_W(10), .BOARD_H(20), .SPAWN_X(3)) dut (
        .clk(clk), .reset_n(reset_n), .control(control), .state(state),
        .next_kind(next_kind), .next_ack(next_ack),
        .cand_x(cand_x), .cand_y(cand_y), .cand_rot(cand_rot), .cand_kind(cand_kind),
        .chk_req(chk_req), .chk_done(chk_done), .chk_hit(chk_hit),
        .lock_req(lock_req), .lock_done(lock_done),
        .clr_req(clr_req), .clr_done(clr_done), .clr_lines(clr_lines),
        .score(score)
    );

    typedef struct {int x; int y; int r; int k;} cand_t;

    int errors = 0, checks = 0;
    cand_t exp_q[$];
    logic [2:0] gen_seq [256];
    int gen_idx = 0;
    int chk_seen = 0, acks_seen = 0, locks_seen = 0, clrs_seen = 0;
    logic prev_chk = 0, prev_lock = 0, prev_clr = 0, prev_ack = 0;
    cand_t mon_e;

    // environment: collision rule and line count handed back by the clear engine
    int hit_y = 18;
    bit force_hit = 0;
    int lines_next = 0;
    bit inject_en = 0;

    // reference model of the piece, hold slot and score
    int mx, my, mrot, mkind, mhk, mgen = 0;
    bit mhv, mhu, m_over;
    int mscore = 0, exp_acks = 0, exp_locks = 0;
    int pts [5] = '{0, 100, 300, 500, 800};

    function automatic bit collide(int cx, int cy);
        return force_hit || cx < 0 || cx > 6 || cy >= hit_y;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: pops the scoreboard on each check request and tracks pulses
    always @(negedge clk) begin
        if (chk_req) begin
            chk_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_chk_req: got (%0d,%0d,%0d,%0d) expected none",
                         cand_x, cand_y, cand_rot, cand_kind);
            end else begin
                mon_e = exp_q.pop_front();
                if (int'(cand_x) != mon_e.x || int'(cand_y) != mon_e.y ||
                    int'(cand_rot) != mon_e.r || int'(cand_kind) != mon_e.k) begin
                    errors++;
                    $display("FAIL candidate: got (%0d,%0d,%0d,%0d) expected (%0d,%0d,%0d,%0d)",
                             cand_x, cand_y, cand_rot, cand_kind, mon_e.x, mon_e.y, mon_e.r, mon_e.k);
                end
            end
        end
        if (chk_req || lock_req || clr_req || next_ack) begin
            checks++;
            if ((chk_req && prev_chk) || (lock_req && prev_lock) || (clr_req && prev_clr) || (next_ack && prev_ack)) begin
                errors++;
                $display("FAIL pulse_width: got request high two cycles expected one");
            end
        end
        if (next_ack) begin
            acks_seen++;
            gen_idx++;
            next_kind = gen_seq[gen_idx % 256];
        end
        if (lock_req) locks_seen++;
        if (clr_req) clrs_seen++;
        prev_chk = chk_req; prev_lock = lock_req; prev_clr = clr_req; prev_ack = next_ack;
    end

    // Checker, board-writer and line-clear responders with random latency
    int cc = 0, lc = 0, rc = 0;
    bit hit_p;
    always @(negedge clk) begin
        chk_done = 0; chk_hit = 0; lock_done = 0; clr_done = 0;
        if (!reset_n) begin
            cc = 0; lc = 0; rc = 0;
        end else begin
            if (inject_en && state == NEW) begin
                chk_done = 1; chk_hit = 1;
            end
            if (chk_req) begin
                cc = $urandom_range(1, 3);
                hit_p = collide(int'(cand_x), int'(cand_y));
            end else if (cc > 0) begin
                cc--;
                if (cc == 0) begin chk_done = 1; chk_hit = hit_p; end
            end
            if (lock_req) lc = $urandom_range(1, 3);
            else if (lc > 0) begin lc--; if (lc == 0) lock_done = 1; end
            if (clr_req) rc = $urandom_range(1, 3);
            else if (rc > 0) begin
                rc--;
                if (rc == 0) begin clr_done = 1; clr_lines = 3'(lines_next); end
            end
        end
    end

    function automatic int gk(int i);
        return int'(gen_seq[i % 256]);
    endfunction

    task automatic m_spawn(input int k, input bit from_hold);
        mx = 3; my = 0; mrot = 0; mkind = k; mhu = from_hold;
        exp_q.push_back('{3, 0, 0, k});
        if (collide(3, 0)) m_over = 1;
    endtask

    task automatic m_lock();
        exp_locks++;
        mscore = mscore + pts[lines_next];
        if (mscore > 65535) mscore = 65535;
        exp_acks++;
        m_spawn(gk(mgen), 0);
        mgen++;
    endtask

    task automatic predict(input state_type c);
        cand_t k;
        int nk;
        k = '{mx, my, mrot, mkind};
        case (c)
            LEFT:       k.x = k.x - 1;
            RIGHT:      k.x = k.x + 1;
            DOWN, DROP: k.y = k.y + 1;
            ROTATE:     k.r = (k.r + 1) % 4;
            ROTATE_REV: k.r = (k.r + 3) % 4;
            BAR:        k.k = 0;
            default: ;
        endcase
        if (c == HOLD) begin
            if (mhu) return;
            if (mhv) nk = mhk;
            else begin nk = gk(mgen); mgen++; exp_acks++; end
            mhk = mkind; mhv = 1;
            m_spawn(nk, 1);
        end else if (c == DROP) begin
            while (1) begin
                exp_q.push_back(k);
                if (collide(k.x, k.y)) break;
                my = k.y;
                k.y = k.y + 1;
            end
            m_lock();
        end else begin
            exp_q.push_back(k);
            if (!collide(k.x, k.y)) begin
                mx = k.x; my = k.y; mrot = k.r; mkind = k.k;
            end else if (c == DOWN) begin
                m_lock();
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (state == WAIT || state == OVER) return;
        end
        chk("idle_timeout", int'(state), int'(WAIT));
    endtask

    task automatic check_idle();
        chk("state", int'(state), m_over ? int'(OVER) : int'(WAIT));
        chk("score", int'(score), mscore);
        chk("pending_checks", exp_q.size(), 0);
        chk("next_acks", acks_seen, exp_acks);
        chk("lock_reqs", locks_seen, exp_locks);
        chk("clr_reqs", clrs_seen, exp_locks);
    endtask

    task automatic issue(input state_type c);
        predict(c);
        control = c;
        @(posedge clk);
        #1 control = NONE;
        wait_idle();
        check_idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0;
        #1;
        chk("rst_state", int'(state), int'(INIT));
        chk("rst_score", int'(score), 0);
        chk("rst_reqs", int'({chk_req, lock_req, clr_req, next_ack}), 0);
        chk("rst_cand", int'({cand_x, cand_y, cand_rot, cand_kind}), 0);
        exp_q.delete();
        mscore = 0; mhv = 0; mhu = 0; m_over = 0; mhk = 0;
        repeat (3) @(negedge clk);
        inject_en = 1;
        #1 reset_n = 1;
        chk("release_init", int'(state), int'(INIT));
        exp_acks++;
        m_spawn(gk(mgen), 0);
        mgen++;
        @(negedge clk);
        chk("seq_new", int'(state), int'(NEW));
        chk("seq_ack", int'(next_ack), 1);
        @(negedge clk);
        chk("seq_check", int'(state), int'(CHECK));
        wait_idle();
        inject_en = 0;
        check_idle();
    endtask

    state_type cmds [8] = '{LEFT, RIGHT, DOWN, DROP, HOLD, ROTATE, ROTATE_REV, BAR};
    int c0;

    initial begin
        for (int i = 0; i < 256; i++) gen_seq[i] = 3'($urandom_range(0, 6));
        next_kind = gen_seq[0];
        do_reset();

        // move left: rejected first, then accepted
        force_hit = 1;
        issue(LEFT);
        force_hit = 0;
        issue(LEFT);
        chk("x_after_left", int'(cand_x), 2);

        // drop onto floor at row 18: 18 down checks plus the respawn check
        hit_y = 18; lines_next = 1;
        c0 = chk_seen;
        issue(DROP);
        chk("drop_checks", chk_seen - c0, 19);

        // two holds within one piece
        issue(HOLD);
        c0 = chk_seen;
        issue(HOLD);
        chk("hold2_no_check", chk_seen - c0, 0);

        for (int n = 0; n < 200; n++) begin
            hit_y = $urandom_range(6, 19);
            lines_next = $urandom_range(0, 4);
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
                chk("idle_none", int'(state), int'(WAIT));
            end
            issue(cmds[$urandom_range(0, 7)]);
        end

        // four-line clears until the score saturates, plus one more
        hit_y = 2; lines_next = 4;
        for (int n = 0; n < 100 && mscore < 65535; n++) issue(DROP);
        issue(DROP);
        chk("score_sat", int'(score), 16'hFFFF);

        // blocked spawn ends the game; OVER stays silent until reset
        force_hit = 1; lines_next = 0;
        issue(DOWN);
        c0 = chk_seen + acks_seen + locks_seen + clrs_seen;
        repeat (20) @(negedge clk);
        chk("over_hold", int'(state), int'(OVER));
        chk("over_silent", chk_seen + acks_seen + locks_seen + clrs_seen, c0);
        force_hit = 0; hit_y = 18;
        do_reset();
        issue(RIGHT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
